timestamp_cntr_mc: RTL and testbench
====================================

TIMESTAMP_CNTR_MC -- requirements
Module: timestamp_cntr_mc

Interface
REQ-001 Parameter FINE_W, default 13: fine counter width in bits.
REQ-002 Parameter COARSE_W, default 8: coarse counter width in bits.
REQ-003 Parameter N_CH, default 4, range 1..16: number of stop channels.
REQ-004 Port clk, input, 1: sole clock; all logic samples on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: start of measurement, sampled per edge.
REQ-007 Port stop, input, N_CH: per-channel stop strobes, sampled per edge.
REQ-008 Port ts_valid, output, 1: a timestamp is presented.
REQ-009 Port ts_ready, input, 1: the consumer accepts the presented timestamp.
REQ-010 Port ts_ch, output, max(1,clog2(N_CH)): channel index of the presented timestamp.
REQ-011 Port ts_fine, output, FINE_W: fine part of the presented timestamp.
REQ-012 Port ts_coarse, output, COARSE_W: coarse part of the presented timestamp.
REQ-013 Port busy, output, 1: high whenever the state is not IDLE.
REQ-014 Port overflow, output, 1: sticky; the last measurement ended on terminal count with at least one channel not captured.

Function
REQ-015 Counter: a single T = FINE_W + COARSE_W bit counter, {coarse, fine}. Coarse increments on the edge where fine wraps from all-ones to 0. MAX = 2^T - 1.
REQ-016 FSM states are IDLE, RUN and DRAIN.
REQ-017 IDLE: start sampled high -> counter = 0, captured/pending flags cleared, overflow cleared, next state RUN.
REQ-018 RUN: counter increments by 1 per edge. A start pulse while in RUN is ignored.
REQ-019 RUN: stop[i] high on an edge while channel i is uncaptured -> capture register i = counter + 1, captured[i] and pending[i] set. Timestamp n = number of edges from the start edge to the stop edge.
REQ-020 Further stop[i] pulses after channel i is captured are ignored until the next accepted start.
REQ-021 Simultaneous stops on several channels on one edge are all captured with the same value.
REQ-022 Stop pulses on the same edge as the accepted start are ignored.
REQ-023 Stops sampled in IDLE or DRAIN are ignored.
REQ-024 RUN -> DRAIN when every channel is captured, effective on the edge of the last capture.
REQ-025 RUN -> DRAIN on the edge where the counter equals MAX:
- stops on that edge are ignored;
- overflow is set if any channel is uncaptured.
REQ-026 DRAIN -> IDLE on the edge where no channel is pending and the output register is empty or is being transferred.
REQ-027 Start pulses in DRAIN are ignored.
REQ-028 Output register loading: when the output register is empty, or a transfer occurs, it loads the lowest-index pending channel and clears that pending bit on the same edge.
REQ-029 Capture-to-ts_valid latency: ts_valid rises one edge after the capture edge.
REQ-030 Transfer occurs on an edge where ts_valid and ts_ready are both high.
REQ-031 While ts_valid is high and ts_ready is low, ts_ch, ts_fine and ts_coarse hold stable.
REQ-032 A new capture on a lower-index channel never pre-empts the presented timestamp.
REQ-033 Back-to-back transfers: with ts_ready held high, one timestamp transfers per cycle.
REQ-034 No timestamp is lost or duplicated. Each captured channel is presented exactly once per measurement.
REQ-035 busy is a registered function of state. It is high from the edge after the accepted start until the state returns to IDLE.

Reset
REQ-036 Reset low asynchronously forces the following, regardless of clk:
- state to IDLE;
- counter, capture registers and captured/pending flags to 0;
- output register empty;
- ts_valid, ts_ch, ts_fine, ts_coarse, busy and overflow to 0.
REQ-037 Reset low mid-RUN or mid-DRAIN discards all captured data; no partial timestamp appears after release.
REQ-038 After reset rises, the first start sampled high starts a measurement normally.

Verification (N_CH=4, FINE_W=13, COARSE_W=8)
REQ-039 Start at edge k; stop[2] at k+10000; ts_ready=1 -> ts_valid at k+10001 with ts_ch=2, ts_coarse=1, ts_fine=1808; busy stays high until all channels are handled.
REQ-040 stop[3] and stop[0] both at k+5, ts_ready=0 for 20 cycles, then 1 ->
- ch0 is presented first, held stable for 20 cycles, value fine=5;
- ch3 follows on the next cycle, value fine=5.
REQ-041 All four channels stopped at k+3, k+4, k+4, k+7 -> DRAIN at k+7; four transfers; IDLE after the last transfer; overflow=0.
REQ-042 Only stop[1] at k+100; no other stops ->
- at edge k+2097151: DRAIN, overflow=1;
- only ch1 is presented, value 100;
- a stop[0] at k+2097151 is ignored;
- the next start clears overflow.
REQ-043 Mid-run reset pulse at k+50 after stop[0] at k+20 -> all outputs 0 immediately; no ts_valid after release; a new start at k+60 with stop[0] at k+63 yields fine=3.
REQ-044 Repeated stop[1] at k+8 and k+9, a start at k+12, and a stop[2] on the start edge k -> a single ch1 timestamp of value 8; no ch2 capture; the start at k+12 is ignored.

Source files
------------

// File: rtl/timestamp_cntr_mc.sv
// Multi-channel time-to-digital stamp counter: one {coarse,fine} counter,
// per-channel stop capture, and a single valid/ready output register drained in channel order.
module timestamp_cntr_mc #(
  parameter int FINE_W   = 13,
  parameter int COARSE_W = 8,
  parameter int N_CH     = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [N_CH-1:0]                           stop,
  output logic                                      ts_valid,
  input  logic                                      ts_ready,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ts_ch,
  output logic [FINE_W-1:0]                         ts_fine,
  output logic [COARSE_W-1:0]                       ts_coarse,
  output logic                                      busy,
  output logic                                      overflow,
  output logic [1:0]                                dbg_state
);

  localparam int T    = FINE_W + COARSE_W;
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_n;
  logic [T-1:0]        cnt_q, cnt_inc;
  logic [N_CH-1:0]     captured_q, captured_n;
  logic [N_CH-1:0]     pending_q, pending_n;
  logic [T-1:0]        cap_q [N_CH];
  logic                out_valid_q;
  logic [CH_W-1:0]     out_ch_q;
  logic [FINE_W-1:0]   out_fine_q;
  logic [COARSE_W-1:0] out_coarse_q;
  logic                busy_q, overflow_q;

  // FSM output decode
  logic            clear_run, run_cnt, ovf_set;
  logic [N_CH-1:0] cap_vec;
  logic            at_max, all_cap;
  // Output handshake: a word transfers on an edge where ts_valid && ts_ready;
  // while ts_valid is high and ts_ready low the word holds unchanged.
  logic            xfer, load_ok, has_pend;
  logic [CH_W-1:0] sel;

  assign cnt_inc = cnt_q + {{(T-1){1'b0}}, 1'b1};
  // The edge that brings the counter to MAX is the last one of the run.
  assign at_max  = (cnt_inc == {T{1'b1}});
  assign all_cap = &(captured_q | cap_vec);
  assign xfer    = out_valid_q & ts_ready;
  assign load_ok = ~out_valid_q | xfer;
  assign has_pend = |pending_q;

  always_comb begin
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = CH_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      busy_q  <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (at_max || all_cap) state_n = DRAIN;
      DRAIN:   if (!has_pend && load_ok) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    clear_run = 1'b0;
    run_cnt   = 1'b0;
    ovf_set   = 1'b0;
    cap_vec   = '0;
    case (state_q)
      IDLE: clear_run = start;
      RUN: begin
        run_cnt = 1'b1;
        if (at_max) ovf_set = ~&captured_q;
        else        cap_vec = stop & ~captured_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    captured_n = captured_q | cap_vec;
    pending_n  = pending_q;
    if (load_ok && has_pend) pending_n[sel] = 1'b0;
    pending_n = pending_n | cap_vec;
    if (clear_run) begin
      captured_n = '0;
      pending_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      captured_q <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (clear_run)    cnt_q <= '0;
      else if (run_cnt) cnt_q <= cnt_inc;
      captured_q <= captured_n;
      pending_q  <= pending_n;
      if (clear_run)    overflow_q <= 1'b0;
      else if (ovf_set) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) cap_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cap_vec[i]) cap_q[i] <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_fine_q   <= '0;
      out_coarse_q <= '0;
    end else if (load_ok) begin
      out_valid_q <= has_pend;
      if (has_pend) begin
        out_ch_q     <= sel;
        out_fine_q   <= cap_q[sel][FINE_W-1:0];
        out_coarse_q <= cap_q[sel][T-1:FINE_W];
      end
    end
  end

  assign ts_valid  = out_valid_q;
  assign ts_ch     = out_ch_q;
  assign ts_fine   = out_fine_q;
  assign ts_coarse = out_coarse_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_timestamp_cntr_mc.sv
// Bench for timestamp_cntr_mc: cycle tables plus directed multi-cycle sequences;
// a narrow second instance reaches terminal count quickly.
module tb_timestamp_cntr_mc;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start, ts_ready, ts_valid, busy, overflow;
  logic [3:0]  stop;
  logic [1:0]  ts_ch, dbg_state;
  logic [12:0] ts_fine;
  logic [7:0]  ts_coarse;

  logic        s_start, s_ready, s_valid, s_busy, s_ovf;
  logic [3:0]  s_stop;
  logic [1:0]  s_ch, s_state;
  logic [2:0]  s_fine;
  logic [1:0]  s_coarse;

  timestamp_cntr_mc #(.FINE_W(13), .COARSE_W(8), .N_CH(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_ch(ts_ch),
    .ts_fine(ts_fine), .ts_coarse(ts_coarse), .busy(busy),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  timestamp_cntr_mc #(.FINE_W(3), .COARSE_W(2), .N_CH(4)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .stop(s_stop),
    .ts_valid(s_valid), .ts_ready(s_ready), .ts_ch(s_ch),
    .ts_fine(s_fine), .ts_coarse(s_coarse), .busy(s_busy),
    .overflow(s_ovf), .dbg_state(s_state)
  );

  typedef struct packed {
    logic        start;
    logic [3:0]  stop;
    logic        ready;
    logic        exp_valid;
    logic [1:0]  exp_ch;
    logic [12:0] exp_fine;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[$];
  logic [22:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int k;
  logic sb_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // scoreboard: every transfer on the wide instance must match the queue head
  task automatic tick();
    logic [22:0] got, e;
    if (sb_en && ts_valid && ts_ready) begin
      got = {ts_ch, ts_coarse, ts_fine};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra actual=%0h expected=none", got);
      end else begin
        e = exp_q.pop_front();
        chk("sb_xfer", {9'd0, got}, {9'd0, e});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input int ch, input int v);
    exp_q.push_back({ch[1:0], v[20:0]});
  endtask

  task automatic run_to(input int n);
    while (cyc - k < n) tick();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (dbg_state != S_IDLE && n < 50) begin
      tick();
      n++;
    end
    chk(nm, {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic vec_t mk(input logic st, input logic [3:0] sp, input logic ev,
                              input logic [1:0] ec, input logic [12:0] ef, input logic [1:0] es);
    vec_t v;
    v.start = st; v.stop = sp; v.ready = 1'b1;
    v.exp_valid = ev; v.exp_ch = ec; v.exp_fine = ef; v.exp_state = es;
    return v;
  endfunction

  task automatic idle_vecs(input int n);
    for (int i = 0; i < n; i++) vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 2'd0, 13'd0, S_RUN));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = '0; ts_ready = 1'b0;
    s_start = 1'b0; s_stop = '0; s_ready = 1'b0;

    // four channels at +3,+4,+4,+7 with ts_ready high
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 2'd0, 13'd0, S_RUN));
    idle_vecs(2);
    vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 2'd0, 13'd0, S_RUN));
    vecs.push_back(mk(1'b0, 4'b0110, 1'b1, 2'd0, 13'd3, S_RUN));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 2'd1, 13'd4, S_RUN));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 2'd2, 13'd4, S_RUN));
    vecs.push_back(mk(1'b0, 4'b1000, 1'b0, 2'd0, 13'd0, S_DRAIN));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 2'd3, 13'd7, S_DRAIN));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 2'd0, 13'd0, S_IDLE));
    // stop on start edge, repeated stop[1], start while running
    vecs.push_back(mk(1'b1, 4'b0100, 1'b0, 2'd0, 13'd0, S_RUN));
    idle_vecs(7);
    vecs.push_back(mk(1'b0, 4'b0010, 1'b0, 2'd0, 13'd0, S_RUN));
    vecs.push_back(mk(1'b0, 4'b0010, 1'b1, 2'd1, 13'd8, S_RUN));
    idle_vecs(2);
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 2'd0, 13'd0, S_RUN));
    idle_vecs(7);
    vecs.push_back(mk(1'b0, 4'b1101, 1'b0, 2'd0, 13'd0, S_DRAIN));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 2'd0, 13'd20, S_DRAIN));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 2'd2, 13'd20, S_DRAIN));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 2'd3, 13'd20, S_DRAIN));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 2'd0, 13'd0, S_IDLE));

    #12;
    chk("rst_valid", {31'd0, ts_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("rst_data", {9'd0, ts_ch, ts_coarse, ts_fine}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      start = vecs[i].start; stop = vecs[i].stop; ts_ready = vecs[i].ready;
      tick();
      chk($sformatf("vec%0d_state", i), {30'd0, dbg_state}, {30'd0, vecs[i].exp_state});
      chk($sformatf("vec%0d_valid", i), {31'd0, ts_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, (vecs[i].exp_state != S_IDLE)});
      chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, 32'd0);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_ch", i), {30'd0, ts_ch}, {30'd0, vecs[i].exp_ch});
        chk($sformatf("vec%0d_data", i), {11'd0, ts_coarse, ts_fine}, {19'd0, vecs[i].exp_fine});
      end
    end
    start = 1'b0; stop = '0;
    sb_en = 1'b1;

    // long run: stop[2] at +10000 lands in coarse=1, fine=1808
    ts_ready = 1'b1;
    start = 1'b1; tick(); k = cyc; start = 1'b0;
    run_to(9999);
    stop = 4'b0100; tick(); stop = '0;
    push(2, cyc - k);
    chk("long_lat0", {31'd0, ts_valid}, 32'd0);
    tick();
    chk("long_valid", {31'd0, ts_valid}, 32'd1);
    chk("long_ch", {30'd0, ts_ch}, 32'd2);
    chk("long_coarse", {24'd0, ts_coarse}, 32'd1);
    chk("long_fine", {19'd0, ts_fine}, 32'd1808);
    chk("long_busy", {31'd0, busy}, 32'd1);
    stop = 4'b1011; tick(); stop = '0;
    push(0, cyc - k); push(1, cyc - k); push(3, cyc - k);
    drain("long_drain");

    // simultaneous stops with consumer stalled
    ts_ready = 1'b0;
    start = 1'b1; tick(); k = cyc; start = 1'b0;
    run_to(4);
    stop = 4'b1001; tick(); stop = '0;
    push(0, 5); push(3, 5);
    tick();
    chk("stall_valid", {31'd0, ts_valid}, 32'd1);
    chk("stall_ch", {30'd0, ts_ch}, 32'd0);
    chk("stall_fine", {19'd0, ts_fine}, 32'd5);
    for (int i = 0; i < 19; i++) begin
      tick();
      chk("stall_hold", {9'd0, ts_valid, ts_ch, ts_coarse, ts_fine}, {9'd0, 1'b1, 2'd0, 8'd0, 13'd5});
    end
    ts_ready = 1'b1;
    tick();
    chk("stall_next_ch", {30'd0, ts_ch}, 32'd3);
    chk("stall_next_fine", {19'd0, ts_fine}, 32'd5);
    chk("stall_next_valid", {31'd0, ts_valid}, 32'd1);
    tick();
    chk("stall_empty", {31'd0, ts_valid}, 32'd0);
    stop = 4'b0110; tick(); stop = '0;
    push(1, cyc - k); push(2, cyc - k);
    drain("stall_drain");

    // asynchronous reset mid-run discards the captured stamp
    ts_ready = 1'b0;
    start = 1'b1; tick(); k = cyc; start = 1'b0;
    run_to(19);
    stop = 4'b0001; tick(); stop = '0;
    run_to(49);
    chk("prerst_valid", {31'd0, ts_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out", {8'd0, ts_valid, busy, overflow, dbg_state, ts_ch, ts_coarse, ts_fine}, 32'd0);
    #1 reset = 1'b1;
    exp_q.delete();
    ts_ready = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 9; i++) begin
        tick();
        if (ts_valid || busy) seen = 1'b1;
      end
      chk("postrst_quiet", {31'd0, seen}, 32'd0);
    end
    start = 1'b1; tick(); k = cyc; start = 1'b0;
    run_to(2);
    stop = 4'b0001; tick();
    push(0, 3);
    stop = 4'b1110; tick(); stop = '0;
    push(1, 4); push(2, 4); push(3, 4);
    chk("postrst_ch", {30'd0, ts_ch}, 32'd0);
    chk("postrst_fine", {19'd0, ts_fine}, 32'd3);
    drain("postrst_drain");

    // terminal count on the narrow instance (MAX = 31)
    s_ready = 1'b1;
    s_start = 1'b1; tick(); k = cyc; s_start = 1'b0;
    run_to(9);
    s_stop = 4'b0010; tick(); s_stop = '0;
    tick();
    chk("ovf_ts", {25'd0, s_valid, s_ch, s_coarse, s_fine}, {25'd0, 1'b1, 2'd1, 2'd1, 3'd2});
    run_to(30);
    chk("ovf_pre_state", {30'd0, s_state}, {30'd0, S_RUN});
    chk("ovf_pre_flag", {31'd0, s_ovf}, 32'd0);
    s_stop = 4'b0001; tick(); s_stop = '0;
    chk("ovf_state", {30'd0, s_state}, {30'd0, S_DRAIN});
    chk("ovf_flag", {31'd0, s_ovf}, 32'd1);
    tick();
    chk("ovf_idle", {30'd0, s_state}, {30'd0, S_IDLE});
    chk("ovf_no_ts", {31'd0, s_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, s_ovf}, 32'd1);
    s_start = 1'b1; tick(); s_start = 1'b0;
    chk("ovf_clear", {31'd0, s_ovf}, 32'd0);
    chk("ovf_restart_busy", {31'd0, s_busy}, 32'd1);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
